// File: rtl/i2c_target_regs.sv
// I2C target responder with a 16 x 8-bit register file shared with a local parallel port.
// Optional SCL/SDA glitch filter is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         FILTER_LEN  = 4
) (
    input  logic       io_mainClk,
    input  logic       io_asyncResetn,
    input  logic       io_i2c_scl_read,
    input  logic       io_i2c_sda_read,
    output logic       io_i2c_sda_write,
    input  logic [3:0] io_bus_addr,
    input  logic [7:0] io_bus_wdata,
    input  logic       io_bus_we,
    output logic [7:0] io_bus_rdata,
    output logic       io_wrStrobe,
    output logic [3:0] io_wrAddr,
    output logic       io_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl;
    logic       w_sda;
    logic       r_scl_prev;
    logic       r_sda_prev;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], io_i2c_scl_read};
            r_sda_sync <= {r_sda_sync[0], io_i2c_sda_read};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] r_scl_cnt;
    logic [CNT_W-1:0] r_sda_cnt;
    logic             r_scl_filt;
    logic             r_sda_filt;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            if (r_scl_sync[1] == r_scl_filt) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_scl_filt <= r_scl_sync[1];
                r_scl_cnt  <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end

            if (r_sda_sync[1] == r_sda_filt) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_sda_filt <= r_sda_sync[1];
                r_sda_cnt  <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [3:0] r_ptr;
    logic [3:0] w_ptr_nxt;
    logic       r_sda_out;
    logic       w_sda_out_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_first;
    logic       w_first_nxt;
    logic       w_wr_en;
    logic [7:0] w_byte;
    logic [7:0] r_regs [16];
    logic [7:0] r_rdata;

    assign w_byte = {r_shift[6:0], w_sda};

    // NOTE: every output gets a default first so no path infers a latch; blocking '=' here, '<=' only in always_ff.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_out_nxt = r_sda_out;
        w_busy_nxt    = r_busy;
        w_first_nxt   = r_first;
        w_wr_en       = 1'b0;

        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_out_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_out_nxt = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == TARGET_ADDR && w_byte[7:1] != 7'h00) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_first_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_out_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        w_bit_cnt_nxt = '0;
                        if (r_shift[0]) begin
                            w_state_nxt = S_RD_DATA;
                            w_shift_nxt = r_regs[r_ptr];
                        end else begin
                            w_state_nxt = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_fall) begin
                        w_sda_out_nxt = 1'b1;
                    end else if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_WR_ACK;
                            if (r_first) begin
                                w_ptr_nxt   = w_byte[3:0];
                                w_first_nxt = 1'b0;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_ptr_nxt = r_ptr + 4'd1;
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_out_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        w_state_nxt   = S_WR_DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
                S_RD_DATA: begin
                    // Each falling edge presents the current MSB; the rising edge moves on to the next bit.
                    if (w_scl_fall) begin
                        w_sda_out_nxt = r_shift[7];
                    end else if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_RD_ACK;
                            w_ptr_nxt   = r_ptr + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_out_nxt = 1'b1;
                    end else if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_state_nxt   = S_RD_DATA;
                            w_shift_nxt   = r_regs[r_ptr];
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_sda_out  <= 1'b1;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sda_out  <= w_sda_out_nxt;
            r_busy     <= w_busy_nxt;
            r_first    <= w_first_nxt;
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    // NOTE: the register bank has a defined reset value, so it is built from resettable flops, not RAM.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (io_bus_we) begin
                r_regs[io_bus_addr] <= io_bus_wdata;
            end
            // Placed after the local write so the I2C commit wins a same-index collision.
            if (w_wr_en) begin
                r_regs[r_ptr] <= w_byte;
            end
            r_rdata <= r_regs[io_bus_addr];
        end
    end

    assign io_i2c_sda_write = r_sda_out;
    assign io_busy          = r_busy;
    assign io_wrStrobe      = w_wr_en;
    assign io_wrAddr        = r_ptr;
    assign io_bus_rdata     = r_rdata;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bit-banged I2C controller, byte-level register model,
// directed scenarios plus randomized transactions.
module tb_i2c_target_regs;

    localparam int Q = 8;  // quarter SCL period in system clocks

    logic       clk;
    logic       rst_n;
    logic       scl_drv;
    logic       sda_drv;
    logic       sda_line;
    logic       sda_write;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic [7:0] bus_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic       busy;

    assign sda_line = sda_drv & sda_write;

    i2c_target_regs dut (
        .io_mainClk      (clk),
        .io_asyncResetn  (rst_n),
        .io_i2c_scl_read (scl_drv),
        .io_i2c_sda_read (sda_line),
        .io_i2c_sda_write(sda_write),
        .io_bus_addr     (bus_addr),
        .io_bus_wdata    (bus_wdata),
        .io_bus_we       (bus_we),
        .io_bus_rdata    (bus_rdata),
        .io_wrStrobe     (wr_strobe),
        .io_wrAddr       (wr_addr),
        .io_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    logic [3:0] exp_strobe [$];
    logic [3:0] got_strobe [$];
    logic [7:0] tx_q [$];
    int         sda_low_cycles = 0;
    bit         coll_seen;

    always @(negedge clk) begin
        if (rst_n && wr_strobe) got_strobe.push_back(wr_addr);
        if (!sda_write) sda_low_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    task automatic put_bit(input logic b);
        sda_drv = b; tick(Q);
        scl_drv = 1'b1; tick(2 * Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    // ack returns the line level in the ninth clock: 0 means acknowledged.
    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_addr = a;
        tick(1);
        d = bus_rdata;
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick(1);
        bus_we    = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic check_all_regs();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            bus_read(4'(i), d);
            check($sformatf("reg%0d", i), d, m_regs[i]);
        end
    endtask

    task automatic check_strobes();
        check("strobe_count", got_strobe.size(), exp_strobe.size());
        while (got_strobe.size() > 0 && exp_strobe.size() > 0)
            check("strobe_addr", got_strobe.pop_front(), exp_strobe.pop_front());
        got_strobe.delete();
        exp_strobe.delete();
    endtask

    // START, address+W, first byte, then every byte queued in tx_q, STOP.
    task automatic do_write(input logic [6:0] a7, input logic [7:0] first);
        logic ack;
        bit   match;
        int   low0;
        match = (a7 == 7'h42);
        low0  = sda_low_cycles;
        bus_start();
        put_byte({a7, 1'b0}, ack);
        check("wr_addr_ack", ack, !match);
        check("wr_busy", busy, match);
        put_byte(first, ack);
        check("wr_ptr_ack", ack, !match);
        if (match) m_ptr = first[3:0];
        foreach (tx_q[i]) begin
            put_byte(tx_q[i], ack);
            check("wr_data_ack", ack, !match);
            if (match) begin
                m_regs[m_ptr] = tx_q[i];
                exp_strobe.push_back(m_ptr);
                m_ptr = m_ptr + 4'd1;
            end
        end
        bus_stop();
        check("wr_busy_after_stop", busy, 1'b0);
        if (!match) check("nack_sda_never_low", sda_low_cycles - low0, 0);
        tx_q.delete();
    endtask

    task automatic do_read(input bit set_ptr, input logic [3:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            put_byte(8'h84, ack);
            check("rd_waddr_ack", ack, 1'b0);
            put_byte({4'($urandom), p}, ack);
            check("rd_ptr_ack", ack, 1'b0);
            m_ptr = p;
            bus_start();
            check("rs_busy_kept", busy, 1'b1);
        end
        put_byte(8'h85, ack);
        check("rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, d);
            check("rd_data", d, m_regs[m_ptr]);
            m_ptr = m_ptr + 4'd1;
        end
        check("rd_sda_released", sda_write, 1'b1);
        bus_stop();
        check("rd_busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [6:0] a7;
        int         op;

        rst_n     = 1'b0;
        scl_drv   = 1'b1;
        sda_drv   = 1'b1;
        bus_addr  = 4'd0;
        bus_wdata = 8'd0;
        bus_we    = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        tick(4);
        check("rst_sda", sda_write, 1'b1);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wraddr", wr_addr, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", bus_rdata, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // Pointer then two data bytes.
        tx_q = '{8'hAA, 8'h55};
        do_write(7'h42, 8'h03);
        check_strobes();
        bus_read(4'd4, d);
        check("rdata_addr4", d, 8'h55);

        // Repeated-start read of two bytes.
        do_read(1'b1, 4'd3, 2);

        // Wrong address: silent, no strobe, no register change.
        tx_q.delete();
        do_write(7'h43, 8'h11);
        check_strobes();
        check_all_regs();

        // Pointer wraps 15 -> 0.
        tx_q = '{8'h11, 8'h22};
        do_write(7'h42, 8'h0F);
        check_strobes();
        check_all_regs();

        // Local write colliding with an I2C commit on reg5.
        bus_start();
        put_byte(8'h84, ack);
        check("coll_addr_ack", ack, 1'b0);
        put_byte(8'h05, ack);
        check("coll_ptr_ack", ack, 1'b0);
        coll_seen = 1'b0;
        fork
            put_byte(8'h99, ack);
            begin
                for (int k = 0; k < 40 * Q && !coll_seen; k++) begin
                    @(negedge clk);
                    if (wr_strobe) begin
                        coll_seen = 1'b1;
                        bus_addr  = 4'd5;
                        bus_wdata = 8'h77;
                        bus_we    = 1'b1;
                        @(negedge clk);
                        bus_we    = 1'b0;
                    end
                end
            end
        join
        check("coll_strobe_seen", coll_seen, 1'b1);
        check("coll_data_ack", ack, 1'b0);
        bus_stop();
        m_regs[5] = 8'h99;
        exp_strobe.push_back(4'd5);
        m_ptr = 4'd6;
        check_strobes();
        bus_read(4'd5, d);
        check("coll_reg5", d, 8'h99);

        // Randomized mix of I2C writes, reads, local writes and foreign addresses.
        for (int it = 0; it < 10; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    for (int i = 0; i < $urandom_range(1, 4); i++) tx_q.push_back(8'($urandom));
                    do_write(7'h42, 8'($urandom));
                end
                1: do_read(1'($urandom), 4'($urandom), $urandom_range(1, 4));
                2: begin
                    a7 = 7'($urandom);
                    d  = 8'($urandom);
                    local_write(a7[3:0], d);
                    bus_read(a7[3:0], d);
                    check("local_rdwr", d, m_regs[a7[3:0]]);
                end
                default: begin
                    a7 = 7'($urandom);
                    if (a7 == 7'h42) a7 = 7'h00;
                    tx_q.push_back(8'($urandom));
                    do_write(a7, 8'($urandom));
                end
            endcase
            check_strobes();
        end
        check_all_regs();

        // Reset asserted while the address ACK is on the line.
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 2);
        sda_drv = 1'b1;
        check("ack_driven_low", sda_write, 1'b0);
        scl_drv = 1'b1;
        tick(Q);
        rst_n = 1'b0;
        #1;
        check("rst_sda_async", sda_write, 1'b1);
        tick(4);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        got_strobe.delete();
        tick(4);
        check("post_rst_busy", busy, 1'b0);
        tx_q = '{8'h5A, 8'hC3};
        do_write(7'h42, 8'h0E);
        check_strobes();
        do_read(1'b1, 4'd0, 1);
        do_read(1'b0, 4'd0, 1);
        check_all_regs();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // A 2-cycle SDA dip with SCL high must not be taken as START.
        sda_drv = 1'b0; tick(2);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b0; tick(Q);
        put_byte(8'h84, ack);
        check("glitch_no_start", ack, 1'b1);
        check("glitch_busy", busy, 1'b0);
        bus_stop();
        check_strobes();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) responder with a 16 × 8-bit register file, the counterpart to the SoC's I2C master. It lets an external I2C controller read and write a local register bank over the same open-drain pin structure the toplevel uses: a tristate pad with a pull-up, where the `_write` signal low drives the line low. A local parallel port gives SoC logic direct access to the same registers. The block sits in the toplevel beside the pad instances and connects to the SDA/SCL pad `read`/`write` nets.

## Interface
Parameters:
- `TARGET_ADDR`, default 7'h42: 7-bit I2C address the block responds to.
- `FILTER_LEN`, default 4: stable-sample count for the glitch filter. Used only with `I2C_TARGET_GLITCH_FILTER_EN`.

Ports:
- `io_mainClk`, input, 1: system clock. Must be at least 16 × the SCL frequency.
- `io_asyncResetn`, input, 1: asynchronous, active-low reset.
- `io_i2c_scl_read`, input, 1: SCL pad input.
- `io_i2c_sda_read`, input, 1: SDA pad input.
- `io_i2c_sda_write`, output, 1: SDA drive. 0 pulls low; 1 releases.
- `io_bus_addr`, input, 4: local register index.
- `io_bus_wdata`, input, 8: local write data.
- `io_bus_we`, input, 1: local write strobe.
- `io_bus_rdata`, output, 8: `reg[io_bus_addr]`, registered.
- `io_wrStrobe`, output, 1: one-cycle pulse when an I2C write commits.
- `io_wrAddr`, output, 4: index of that committed write.
- `io_busy`, output, 1: high from an address match until STOP, or until the next START that does not re-address the block.

## Operation
**Input path**
- SCL and SDA pass through a 2-flop synchronizer, then the optional filter.
- Edges are detected against the previous filtered sample.

**Bus conditions**
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Both are recognised in every state.
- START from any state goes to ADDR with the bit counter cleared.
- STOP from any state goes to IDLE and releases SDA.

**State machine**
- IDLE: wait for START.
- ADDR: shift 8 bits MSB-first on SCL rising edges.
  - If the 7-bit address equals `TARGET_ADDR`: go to ADDR_ACK and set `io_busy`.
  - Otherwise: go to IDLE. SDA is never driven, i.e. the block NACKs by staying silent.
- ADDR_ACK: drive SDA=0 for the ACK bit.
  - R/W=0: go to WR_DATA.
  - R/W=1: go to RD_DATA and load the shifter with `reg[ptr]`.
- WR_DATA: receive 8 bits, then go to WR_ACK, which drives ACK.
  - First byte of the transaction: loaded into `ptr[3:0]`; upper 4 bits ignored.
  - Later bytes: written to `reg[ptr]`, `io_wrStrobe` pulses with `io_wrAddr`=ptr, then ptr increments.
- RD_DATA: present 8 bits MSB-first, then go to RD_ACK and release SDA.
  - The increment is applied on entry to RD_ACK.
  - RD_ACK samples the controller's ACK/NACK on SCL rising.
  - ACK (SDA=0): reload the shifter from `reg[ptr]` and continue in RD_DATA.
  - NACK: go to IDLE and wait for STOP or START.

**Pointer and register file**
- ptr is 4 bits and wraps 15 → 0.
- ptr persists across transactions, so a read without a pointer write continues from the last ptr.
- General-call address (7'h00) is ignored.
- Collision: an I2C write and a local write to the same index in the same cycle; the I2C write wins.
- `io_bus_rdata` updates one cycle after the address is presented and reflects writes made in the prior cycle.

## Timing
**Reset values**
- `io_i2c_sda_write`=1, `io_wrStrobe`=0, `io_wrAddr`=0, `io_busy`=0, `io_bus_rdata`=0.
- All registers 0, ptr=0, state IDLE.
- Reset mid-transfer releases SDA immediately (asynchronous).

**Latency**
- Pad to internal sample: 2 cycles (2-flop synchronizer), plus `FILTER_LEN` cycles when the filter is enabled.
- SDA drive changes only on the internal SCL falling edge, one cycle after detection. It is never changed while internal SCL is high.
- `io_wrStrobe` asserts on the cycle of the 8th-bit SCL rising edge detection.
- The register file updates on that same edge.

**Scope**
- No clock stretching: SCL is never driven.

## Configuration
`I2C_TARGET_GLITCH_FILTER_EN`:
- Defined: each synchronized line changes its filtered value only after `FILTER_LEN` consecutive identical samples. Shorter pulses are rejected.
- Undefined: the filter is absent and the synchronizer output is used directly, saving latency and area.

## Test plan
- Write pointer and data: START, 0x84 (addr 0x42, W), 0x03, 0xAA, 0x55, STOP. Required: ACK on every byte, reg3=0xAA, reg4=0x55, two `io_wrStrobe` pulses with `io_wrAddr` 3 then 4, `io_bus_rdata` at addr 4 reads 0x55.
- Repeated-start read: START, 0x84, 0x03, Sr, 0x85, read 2 bytes (ACK then NACK), STOP. Required: 0xAA then 0x55, SDA released after the NACK, `io_busy`=0 after STOP.
- Address mismatch: START, 0x86, 0x11, STOP. Required: SDA held at 1 throughout, no `io_wrStrobe`, no register change.
- Wrap: pointer 0x0F, write 0x11 and 0x22. Required: reg15=0x11, reg0=0x22.
- Collision: local write of 0x77 to reg5 in the same cycle as an I2C commit of 0x99 to reg5. Required: reg5=0x99.
- Reset and filter: assert `io_asyncResetn`=0 while the ACK bit is driven. Required: SDA=1 the same cycle, and the next transaction operates normally. With the filter enabled, a 2-cycle SDA low pulse while SCL is high produces no START.
